// File: rtl/skew_register_bank_if.sv
// Bus bundle for skew_register_bank: enable, flush, input valid and the
// packed lane data in, plus the delayed lane data and per-lane valids out.
`timescale 1ns/1ps

interface skew_register_bank_if #(
    parameter int WIDTH = 34,
    parameter int LANES = 4
);
    logic                     E;
    logic                     F;
    logic                     V;
    logic [LANES*WIDTH-1:0]   D;
    logic [LANES*WIDTH-1:0]   Q;
    logic [LANES-1:0]         QV;

    modport master (output E, F, V, D, input Q, QV);
    modport slave  (input E, F, V, D, output Q, QV);
endinterface

// File: rtl/skew_register_bank.sv
// Per-lane staggered register pipelines for the systolic-array boundary.
// Lane i is a chain of L(i) data+valid registers:
//   MODE 0 (skew)   : L(i) = BASE + i
//   MODE 1 (deskew) : L(i) = BASE + LANES - 1 - i
// E=0 freezes every stage, F=1 kills all valid bits without touching data,
// Rn=0 (synchronous) clears everything and overrides E/F/V.
`timescale 1ns/1ps

module skew_register_bank #(
    parameter int WIDTH = 34,
    parameter int LANES = 4,
    parameter int BASE  = 1,
    parameter int MODE  = 0
) (
    input  logic                  C,
    input  logic                  Rn,
    skew_register_bank_if.slave   bus
);

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        localparam int DEPTH = (MODE == 0) ? (BASE + gi) : (BASE + LANES - 1 - gi);

        logic [DEPTH-1:0][WIDTH-1:0] data_q;
        logic [DEPTH-1:0][WIDTH-1:0] data_d;
        logic [DEPTH-1:0]            valid_q;
        logic [DEPTH-1:0]            valid_d;

        // Next state: hold by default, shift on enable, flush clears valids only.
        always_comb begin
            data_d  = data_q;
            valid_d = valid_q;
            if (bus.E) begin
                data_d[0]  = bus.D[gi*WIDTH +: WIDTH];
                valid_d[0] = bus.V;
                for (int s = 1; s < DEPTH; s++) begin
                    data_d[s]  = data_q[s-1];
                    valid_d[s] = valid_q[s-1];
                end
            end
            if (bus.F) begin
                valid_d = '0;
            end
        end

        // Stage registers with synchronous active-low clear.
        always_ff @(posedge C) begin
            if (!Rn) begin
                data_q  <= '0;
                valid_q <= '0;
            end else begin
                data_q  <= data_d;
                valid_q <= valid_d;
            end
        end

        assign bus.Q[gi*WIDTH +: WIDTH] = data_q[DEPTH-1];
        assign bus.QV[gi]               = valid_q[DEPTH-1];
    end

endmodule
